pr_free_list_bank: RTL and testbench
====================================

// Module: pr_free_list_bank
// PURPOSE
//  - Consumer end of the ROB PR free path: one PRF bank's free list. Accepts freed PRs from the ROB PR free
//    queue and hands free PRs to rename. Checkpoints the head pointer so rename can roll back on mispredict.
//  - Sits in the frontend between the ROB PR free queue (producer) and the rename stage (consumer).
// PARAMETERS
//  - BANK        : default 0; PRF bank index, 0..PRF_BANK_COUNT-1. Forms the low PR bits of deq_PR.
//  - LENGTH      : default FREE_LIST_LENGTH_PER_BANK (32); ring entries, power of 2.
//  - INIT_COUNT  : default 16; free entries at reset.
//  - LOWER_THR   : default FREE_LIST_LOWER_THRESHOLD (8).
//  - UPPER_THR   : default FREE_LIST_UPPER_THRESHOLD (24).
//  - CKPT_COUNT  : default CHECKPOINT_COUNT (8).
// PORTS
//  - CLK            in   1     clock.
//  - RST            in   1     reset: asynchronous, active-high.
//  - enq_valid      in   1     freed PR from ROB free queue. Always accepted; there is no ready.
//  - enq_PR_upper   in   5     upper_PR_t of the freed PR.
//  - deq_valid      out  1     free PR available (count != 0).
//  - deq_PR         out  7     PR_t = {ring[head], BANK}.
//  - deq_ready      in   1     rename takes deq_PR this cycle.
//  - ckpt_save      in   1     save the head pointer into a checkpoint slot.
//  - ckpt_save_idx  in   3     CHECKPOINT_idx_t; slot written by ckpt_save.
//  - ckpt_restore   in   1     restore the head pointer from a checkpoint slot.
//  - ckpt_rest_idx  in   3     CHECKPOINT_idx_t; slot read by ckpt_restore.
//  - count          out  6     tail - head; range 0..LENGTH.
//  - below_lower    out  1     count < LOWER_THR.
//  - above_upper    out  1     count > UPPER_THR.
// BEHAVIOUR
//  - Storage and reset
//    - State: ring[LENGTH] of upper_PR_t, 6b head, 6b tail, ckpt[CKPT_COUNT] of 6b.
//    - Pointer bit 5 is the wrap bit. Ring index = ptr[4:0].
//    - Reset: ring[i] = LENGTH - INIT_COUNT + i for i < INIT_COUNT, else 0. head = 0, tail = INIT_COUNT,
//      every ckpt = 0.
//    - Reset outputs: deq_valid = 1, deq_PR = {5'd16, BANK}, count = 16, below_lower = 0, above_upper = 0.
//  - Dequeue
//    - deq_valid = (head != tail).
//    - deq_PR is driven combinationally from registered head.
//    - deq_ready && deq_valid: head += 1 next edge.
//    - deq_ready with deq_valid = 0: ignored, head unchanged.
//  - Enqueue
//    - enq_valid: ring[tail[4:0]] <= enq_PR_upper and tail += 1 next edge.
//    - No bypass: an enqueue into an empty list makes deq_valid rise in the next cycle.
//  - Checkpoint save
//    - ckpt[ckpt_save_idx] <= head_next, where head_next includes this cycle's dequeue and excludes restore.
//  - Checkpoint restore
//    - head <= ckpt[ckpt_rest_idx]. A restore overrides a same-cycle dequeue.
//    - A same-cycle enqueue still applies to tail.
//    - A same-cycle save still writes head_next (pre-restore), unless save_idx == rest_idx, in which case
//      the slot keeps its old value.
//    - Ring entries are never lost on rollback: at most LENGTH PRs per bank exist, so entries between the
//      restored head and the current head cannot be overwritten by tail.
//  - Count and flags
//    - count = tail - head (6b modular). count == LENGTH is full; count == 0 is empty.
//    - below_lower and above_upper are registered from the next-state count, so they are valid in the same
//      cycle as count.
//    - Pointers wrap modulo 2*LENGTH; the ring index wraps at LENGTH.
//  - Error conditions (simulation assertions)
//    - Enqueue when count == LENGTH and no same-cycle dequeue.
//    - Restore yielding tail - head > LENGTH.
//  - All state returns to reset values immediately on RST assertion, including mid-operation.
// STRUCTURE
//  - Uses corep: upper_PR_t, PR_t, CHECKPOINT_idx_t and the FREE_LIST_* constants.
//  - Add FL_ptr_t (logic [LOG_FREE_LIST_LENGTH_PER_BANK:0]) to corep for reuse by the multi-bank wrapper.
//  - Single flat module. The ckpt array is a small register file; no sub-module is needed.
// TESTING
//  - Reset, no activity -> count = 16, deq_PR = 7'h40 (BANK 0), below_lower = 0, above_upper = 0.
//  - 16 consecutive dequeues -> deq_PR steps through uppers 16..31; then deq_valid = 0, count = 0,
//    below_lower = 1.
//  - From empty, enqueue upper 5 -> deq_valid = 0 in that cycle, 1 in the next, with deq_PR = {5, BANK}.
//  - Save slot 2 at head = 3; dequeue 4 times; restore slot 2 with a same-cycle enqueue -> head = 3,
//    tail += 1, count = tail - 3.
//  - Fill to count = 32 with dequeue+enqueue interleaving across the ring wrap -> above_upper = 1, no
//    assertion fires; values come out in FIFO order.
//  - Assert RST mid-burst with save and restore active -> all outputs show reset values in the next cycle.

Source files
------------

// File: rtl/corep.sv
// Core-wide types and constants shared by the rename / free-list path.
package corep;

  localparam int PRF_BANK_COUNT                = 4;
  localparam int LOG_PRF_BANK_COUNT            = 2;
  localparam int LOG_PR_COUNT                  = 7;
  localparam int FREE_LIST_LENGTH_PER_BANK     = 32;
  localparam int LOG_FREE_LIST_LENGTH_PER_BANK = 5;
  localparam int FREE_LIST_LOWER_THRESHOLD     = 8;
  localparam int FREE_LIST_UPPER_THRESHOLD     = 24;
  localparam int CHECKPOINT_COUNT              = 8;
  localparam int LOG_CHECKPOINT_COUNT          = 3;

  typedef logic [LOG_PR_COUNT-1:0]                      PR_t;
  typedef logic [LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0]   upper_PR_t;
  typedef logic [LOG_CHECKPOINT_COUNT-1:0]              CHECKPOINT_idx_t;
  // Free-list pointer: ring index plus one wrap bit.
  typedef logic [LOG_FREE_LIST_LENGTH_PER_BANK:0]       FL_ptr_t;

endpackage

// File: rtl/pr_free_list_bank.sv
// Free list for one PRF bank: ring of free upper-PR values, head checkpointing
// for rename rollback, and occupancy threshold flags.
module pr_free_list_bank
  import corep::*;
#(
  parameter int BANK       = 0,
  parameter int LENGTH     = FREE_LIST_LENGTH_PER_BANK,
  parameter int INIT_COUNT = 16,
  parameter int LOWER_THR  = FREE_LIST_LOWER_THRESHOLD,
  parameter int UPPER_THR  = FREE_LIST_UPPER_THRESHOLD,
  parameter int CKPT_COUNT = CHECKPOINT_COUNT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            enq_valid,
  input  upper_PR_t       enq_PR_upper,
  output logic            deq_valid,
  output PR_t             deq_PR,
  input  logic            deq_ready,
  input  logic            ckpt_save,
  input  CHECKPOINT_idx_t ckpt_save_idx,
  input  logic            ckpt_restore,
  input  CHECKPOINT_idx_t ckpt_rest_idx,
  output FL_ptr_t         count,
  output logic            below_lower,
  output logic            above_upper
);

  localparam int IDX_W = LOG_FREE_LIST_LENGTH_PER_BANK;
  localparam logic [LOG_PRF_BANK_COUNT-1:0] BANK_BITS = LOG_PRF_BANK_COUNT'(BANK);
  localparam FL_ptr_t LEN_P   = FL_ptr_t'(LENGTH);
  localparam FL_ptr_t LOWER_P = FL_ptr_t'(LOWER_THR);
  localparam FL_ptr_t UPPER_P = FL_ptr_t'(UPPER_THR);

  upper_PR_t ring [LENGTH];
  FL_ptr_t   ckpt [CKPT_COUNT];
  FL_ptr_t   head;
  FL_ptr_t   tail;
  FL_ptr_t   head_after_deq;
  FL_ptr_t   head_next;
  FL_ptr_t   tail_next;
  FL_ptr_t   count_next;
  FL_ptr_t   restore_count;
  logic      deq_fire;
  logic      save_en;
  logic      below_lower_q;
  logic      above_upper_q;

  // Next-state pointers: restore overrides dequeue, and a save whose slot is
  // being restored in the same cycle is dropped so the slot keeps its value.
  always_comb begin
    deq_fire       = deq_ready && deq_valid;
    head_after_deq = head + FL_ptr_t'(deq_fire);
    head_next      = ckpt_restore ? ckpt[ckpt_rest_idx] : head_after_deq;
    tail_next      = tail + FL_ptr_t'(enq_valid);
    count_next     = tail_next - head_next;
    restore_count  = tail_next - ckpt[ckpt_rest_idx];
    save_en        = ckpt_save && !(ckpt_restore && (ckpt_save_idx == ckpt_rest_idx));
  end

  assign deq_valid   = (head != tail);
  assign deq_PR      = {ring[head[IDX_W-1:0]], BANK_BITS};
  assign count       = tail - head;
  assign below_lower = below_lower_q;
  assign above_upper = above_upper_q;

  // Head/tail pointers and flags registered from the next-state occupancy.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head          <= '0;
      tail          <= FL_ptr_t'(INIT_COUNT);
      below_lower_q <= (FL_ptr_t'(INIT_COUNT) < LOWER_P);
      above_upper_q <= (FL_ptr_t'(INIT_COUNT) > UPPER_P);
    end else begin
      head          <= head_next;
      tail          <= tail_next;
      below_lower_q <= (count_next < LOWER_P);
      above_upper_q <= (count_next > UPPER_P);
    end
  end

  // Ring storage: freed PRs land at the tail; reset preloads the upper half.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < LENGTH; i++) begin
        ring[i] <= (i < INIT_COUNT) ? upper_PR_t'(LENGTH - INIT_COUNT + i) : '0;
      end
    end else if (enq_valid) begin
      ring[tail[IDX_W-1:0]] <= enq_PR_upper;
    end
  end

  // Checkpoint register file holding post-dequeue head snapshots.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < CKPT_COUNT; i++) begin
        ckpt[i] <= '0;
      end
    end else if (save_en) begin
      ckpt[ckpt_save_idx] <= head_after_deq;
    end
  end

  // Overflow on enqueue into a full list without a same-cycle dequeue.
  assert property (@(posedge CLK) disable iff (RST)
    !(enq_valid && (count == LEN_P) && !deq_fire));

  // A rollback must never leave more entries than the ring can hold.
  assert property (@(posedge CLK) disable iff (RST)
    ckpt_restore |-> (restore_count <= LEN_P));

endmodule

// File: tb/tb_pr_free_list_bank.sv
// Directed self-checking bench for pr_free_list_bank (BANK 0).
module tb_pr_free_list_bank;
  import corep::*;

  logic            clk;
  logic            rst;
  logic            enq_valid;
  upper_PR_t       enq_PR_upper;
  logic            deq_valid;
  PR_t             deq_PR;
  logic            deq_ready;
  logic            ckpt_save;
  CHECKPOINT_idx_t ckpt_save_idx;
  logic            ckpt_restore;
  CHECKPOINT_idx_t ckpt_rest_idx;
  FL_ptr_t         count;
  logic            below_lower;
  logic            above_upper;

  int pass_count;
  int check_count;

  pr_free_list_bank #(.BANK(0)) dut (
    .CLK          (clk),
    .RST          (rst),
    .enq_valid    (enq_valid),
    .enq_PR_upper (enq_PR_upper),
    .deq_valid    (deq_valid),
    .deq_PR       (deq_PR),
    .deq_ready    (deq_ready),
    .ckpt_save    (ckpt_save),
    .ckpt_save_idx(ckpt_save_idx),
    .ckpt_restore (ckpt_restore),
    .ckpt_rest_idx(ckpt_rest_idx),
    .count        (count),
    .below_lower  (below_lower),
    .above_upper  (above_upper)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enq_valid     = 1'b0;
    enq_PR_upper  = '0;
    deq_ready     = 1'b0;
    ckpt_save     = 1'b0;
    ckpt_save_idx = '0;
    ckpt_restore  = 1'b0;
    ckpt_rest_idx = '0;
  endtask

  task automatic apply_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    step();
    check_count++;
    if (count !== 6'd16) $display("[TB] FAIL reset_count got %0d want 16", count);
    else pass_count++;
    check_count++;
    if (deq_PR !== 7'h40) $display("[TB] FAIL reset_deq_PR got %h want 40", deq_PR);
    else pass_count++;
    check_count++;
    if (deq_valid !== 1'b1) $display("[TB] FAIL reset_deq_valid got %b want 1", deq_valid);
    else pass_count++;
    check_count++;
    if (below_lower !== 1'b0) $display("[TB] FAIL reset_below got %b want 0", below_lower);
    else pass_count++;
    check_count++;
    if (above_upper !== 1'b0) $display("[TB] FAIL reset_above got %b want 0", above_upper);
    else pass_count++;
  endtask

  task automatic test_drain();
    logic [4:0] up;
    for (int i = 0; i < 16; i++) begin
      up = 5'(16 + i);
      check_count++;
      if (deq_PR !== {up, 2'b00}) $display("[TB] FAIL drain_deq_PR[%0d] got %h want %h", i, deq_PR, {up, 2'b00});
      else pass_count++;
      deq_ready = 1'b1;
      step();
      deq_ready = 1'b0;
      check_count++;
      if (below_lower !== ((15 - i) < 8)) $display("[TB] FAIL drain_below[%0d] got %b want %b", i, below_lower, ((15 - i) < 8));
      else pass_count++;
    end
    check_count++;
    if (deq_valid !== 1'b0) $display("[TB] FAIL drain_deq_valid got %b want 0", deq_valid);
    else pass_count++;
    check_count++;
    if (count !== 6'd0) $display("[TB] FAIL drain_count got %0d want 0", count);
    else pass_count++;
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;
    check_count++;
    if (count !== 6'd0) $display("[TB] FAIL empty_deq_ignored got %0d want 0", count);
    else pass_count++;
  endtask

  task automatic test_enq_empty();
    enq_valid    = 1'b1;
    enq_PR_upper = 5'd5;
    #2;
    check_count++;
    if (deq_valid !== 1'b0) $display("[TB] FAIL enq_no_bypass got %b want 0", deq_valid);
    else pass_count++;
    step();
    idle();
    check_count++;
    if (deq_valid !== 1'b1) $display("[TB] FAIL enq_valid_rise got %b want 1", deq_valid);
    else pass_count++;
    check_count++;
    if (deq_PR !== 7'h14) $display("[TB] FAIL enq_deq_PR got %h want 14", deq_PR);
    else pass_count++;
    check_count++;
    if (count !== 6'd1) $display("[TB] FAIL enq_count got %0d want 1", count);
    else pass_count++;
  endtask

  task automatic test_checkpoint();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      deq_ready = 1'b1;
      step();
    end
    idle();
    ckpt_save     = 1'b1;
    ckpt_save_idx = 3'd2;
    step();
    idle();
    for (int i = 0; i < 4; i++) begin
      deq_ready = 1'b1;
      step();
    end
    idle();
    check_count++;
    if (deq_PR !== {5'd23, 2'b00}) $display("[TB] FAIL ckpt_pre_restore got %h want %h", deq_PR, {5'd23, 2'b00});
    else pass_count++;
    ckpt_restore  = 1'b1;
    ckpt_rest_idx = 3'd2;
    enq_valid     = 1'b1;
    enq_PR_upper  = 5'd9;
    step();
    idle();
    check_count++;
    if (deq_PR !== {5'd19, 2'b00}) $display("[TB] FAIL ckpt_restore_PR got %h want %h", deq_PR, {5'd19, 2'b00});
    else pass_count++;
    check_count++;
    if (count !== 6'd14) $display("[TB] FAIL ckpt_restore_count got %0d want 14", count);
    else pass_count++;
    deq_ready     = 1'b1;
    ckpt_save     = 1'b1;
    ckpt_save_idx = 3'd1;
    step();
    idle();
    check_count++;
    if (deq_PR !== {5'd20, 2'b00}) $display("[TB] FAIL ckpt_save_deq_PR got %h want %h", deq_PR, {5'd20, 2'b00});
    else pass_count++;
    deq_ready = 1'b1;
    step();
    step();
    deq_ready     = 1'b1;
    ckpt_save     = 1'b1;
    ckpt_save_idx = 3'd2;
    ckpt_restore  = 1'b1;
    ckpt_rest_idx = 3'd2;
    step();
    idle();
    check_count++;
    if (deq_PR !== {5'd19, 2'b00}) $display("[TB] FAIL restore_over_deq got %h want %h", deq_PR, {5'd19, 2'b00});
    else pass_count++;
    check_count++;
    if (count !== 6'd14) $display("[TB] FAIL restore_over_deq_count got %0d want 14", count);
    else pass_count++;
    deq_ready = 1'b1;
    step();
    idle();
    ckpt_restore  = 1'b1;
    ckpt_rest_idx = 3'd2;
    step();
    idle();
    check_count++;
    if (deq_PR !== {5'd19, 2'b00}) $display("[TB] FAIL same_idx_keeps_slot got %h want %h", deq_PR, {5'd19, 2'b00});
    else pass_count++;
    ckpt_restore  = 1'b1;
    ckpt_rest_idx = 3'd1;
    step();
    idle();
    check_count++;
    if (deq_PR !== {5'd20, 2'b00}) $display("[TB] FAIL ckpt_slot1_PR got %h want %h", deq_PR, {5'd20, 2'b00});
    else pass_count++;
    check_count++;
    if (count !== 6'd13) $display("[TB] FAIL ckpt_slot1_count got %0d want 13", count);
    else pass_count++;
  endtask

  task automatic test_fill_wrap();
    logic [4:0] exp_q[$];
    logic [4:0] head_val;
    apply_reset();
    for (int i = 0; i < 16; i++) exp_q.push_back(5'(16 + i));
    for (int i = 0; i < 16; i++) begin
      head_val = exp_q[0];
      check_count++;
      if (deq_PR !== {head_val, 2'b00}) $display("[TB] FAIL swap_deq_PR[%0d] got %h want %h", i, deq_PR, {head_val, 2'b00});
      else pass_count++;
      deq_ready    = 1'b1;
      enq_valid    = 1'b1;
      enq_PR_upper = 5'(i);
      step();
      void'(exp_q.pop_front());
      exp_q.push_back(5'(i));
    end
    idle();
    for (int k = 0; k < 16; k++) begin
      enq_valid    = 1'b1;
      enq_PR_upper = 5'(16 + k);
      step();
      exp_q.push_back(5'(16 + k));
      idle();
      check_count++;
      if (above_upper !== ((17 + k) > 24)) $display("[TB] FAIL fill_above[%0d] got %b want %b", k, above_upper, ((17 + k) > 24));
      else pass_count++;
    end
    check_count++;
    if (count !== 6'd32) $display("[TB] FAIL fill_count got %0d want 32", count);
    else pass_count++;
    deq_ready    = 1'b1;
    enq_valid    = 1'b1;
    enq_PR_upper = 5'd7;
    step();
    idle();
    void'(exp_q.pop_front());
    exp_q.push_back(5'd7);
    check_count++;
    if (count !== 6'd32) $display("[TB] FAIL full_swap_count got %0d want 32", count);
    else pass_count++;
    for (int i = 0; i < 32; i++) begin
      head_val = exp_q[0];
      check_count++;
      if (deq_PR !== {head_val, 2'b00}) $display("[TB] FAIL full_drain_PR[%0d] got %h want %h", i, deq_PR, {head_val, 2'b00});
      else pass_count++;
      deq_ready = 1'b1;
      step();
      void'(exp_q.pop_front());
    end
    idle();
    check_count++;
    if (deq_valid !== 1'b0) $display("[TB] FAIL full_drain_empty got %b want 0", deq_valid);
    else pass_count++;
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    deq_ready     = 1'b1;
    enq_valid     = 1'b1;
    enq_PR_upper  = 5'd1;
    ckpt_save     = 1'b1;
    ckpt_save_idx = 3'd2;
    step();
    ckpt_restore  = 1'b1;
    ckpt_rest_idx = 3'd3;
    step();
    ckpt_restore  = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check_count++;
    if (count !== 6'd16) $display("[TB] FAIL midrst_count got %0d want 16", count);
    else pass_count++;
    check_count++;
    if (deq_PR !== 7'h40) $display("[TB] FAIL midrst_deq_PR got %h want 40", deq_PR);
    else pass_count++;
    check_count++;
    if (deq_valid !== 1'b1 || below_lower !== 1'b0 || above_upper !== 1'b0)
      $display("[TB] FAIL midrst_flags got v%b b%b a%b want v1 b0 a0", deq_valid, below_lower, above_upper);
    else pass_count++;
    idle();
    step();
    rst = 1'b0;
    deq_ready = 1'b1;
    step();
    idle();
    check_count++;
    if (deq_PR !== 7'h44) $display("[TB] FAIL midrst_ring_PR got %h want 44", deq_PR);
    else pass_count++;
    ckpt_restore  = 1'b1;
    ckpt_rest_idx = 3'd2;
    step();
    idle();
    check_count++;
    if (deq_PR !== 7'h40) $display("[TB] FAIL midrst_ckpt_cleared got %h want 40", deq_PR);
    else pass_count++;
  endtask

  // Scenario sequence and summary.
  initial begin
    pass_count  = 0;
    check_count = 0;
    rst         = 1'b1;
    idle();
    test_reset();
    test_drain();
    test_enq_empty();
    test_checkpoint();
    test_fill_wrap();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
